ctrl_bus_arbiter: RTL and testbench
===================================

CTRL_BUS_ARBITER -- requirements
Module: ctrl_bus_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, number of requesters (fixed at 4 in this revision).
REQ-002 The block SHALL have parameter CB_W, default 17, control-bus width in bits.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, maximum grant length in cycles (range 2..255).
REQ-004 The block SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port req  input  N_REQ  per-requester level request.
REQ-007 The block SHALL have port done  input  N_REQ  per-requester one-cycle release pulse.
REQ-008 The block SHALL have port cbus_in  input  N_REQ*CB_W  flattened requester control words; requester i occupies bits [i*CB_W +: CB_W].
REQ-009 The block SHALL have port clr_err  input  1  clears timeout_err.
REQ-010 The block SHALL have port gnt  output  N_REQ  one-hot grant, registered.
REQ-011 The block SHALL have port owner  output  2  index of the current or last grantee.
REQ-012 The block SHALL have port busy  output  1  high while in GRANT or RELEASE.
REQ-013 The block SHALL have port cbus_out  output  CB_W  control word driven to the ALU datapath.
REQ-014 The block SHALL have port timeout_err  output  1  sticky forced-release flag.

Function
REQ-015 The FSM SHALL have states IDLE, GRANT and RELEASE.
REQ-016 In IDLE with any req high at edge n, the FSM SHALL go to GRANT, and gnt SHALL be one-hot on the winner from cycle n+1.
REQ-017 The winner SHALL be the first asserted req found searching from index ptr upward, modulo 4.
REQ-018 On entry to GRANT, ptr SHALL become (winner+1) mod 4, and owner SHALL become the winner.
REQ-019 In GRANT, cbus_out SHALL equal cbus_in slice [owner], combinational from cbus_in; in every other state cbus_out SHALL be all zeros.
REQ-020 In GRANT, done[owner]=1 or req[owner]=0 at edge m SHALL move the FSM to RELEASE, and gnt SHALL be 0 from cycle m+1.
REQ-021 done bits of non-owners SHALL be ignored.
REQ-022 RELEASE SHALL last exactly one cycle and then go to IDLE, so the earliest next grant is at cycle m+3.
REQ-023 An 8-bit grant counter SHALL clear on GRANT entry and increment each GRANT cycle.
REQ-024 When the counter equals TIMEOUT-1 and no release condition is present, the FSM SHALL go to RELEASE and set timeout_err.
REQ-025 When a release condition and the timeout occur in the same cycle, it SHALL be treated as a normal release and timeout_err SHALL be left unchanged.
REQ-026 timeout_err SHALL clear on clr_err=1; when set and clear coincide, set SHALL win.
REQ-027 busy SHALL be 1 in GRANT and RELEASE and 0 in IDLE.
REQ-028 req rising during GRANT or RELEASE SHALL have no effect until IDLE.

Reset
REQ-029 On reset=1 at a clock edge, all state SHALL clear: state IDLE, gnt 0, owner 0, ptr 0, counter 0, timeout_err 0, busy 0, cbus_out 0.
REQ-030 Reset SHALL take priority over all inputs, including during GRANT; no RELEASE cycle SHALL follow a reset.

Structure
REQ-031 A shared package ctrl_bus_pkg SHALL hold CB_W, N_REQ, the state encoding (IDLE=2'b00, GRANT=2'b01, RELEASE=2'b10) and the TIMEOUT default.
REQ-032 One sub-module rr_pick SHALL be used: a combinational round-robin priority encoder with inputs req and ptr and outputs winner index and valid.
REQ-033 The FSM, counters and output mux SHALL reside in ctrl_bus_arbiter.

Verification
REQ-034 The bench SHALL check reset then req=0001 at cycle 2: gnt=0001 at cycle 3, busy=1, cbus_out=cbus_in[16:0].
REQ-035 The bench SHALL check req=1111 held and each owner pulsing done one cycle after its grant: grant order 0,1,2,3,0, with a 2-cycle gap (gnt=0) between grants.
REQ-036 The bench SHALL check that done[2] while owner=1: no release, and gnt stays 0010.
REQ-037 The bench SHALL check req=0100 held with no done and TIMEOUT=8: gnt drops after 8 grant cycles, timeout_err=1, and it stays 1 until clr_err.
REQ-038 The bench SHALL check reset asserted mid-GRANT: the next cycle has gnt=0, cbus_out=0 and ptr=0, and req=1000 then grants index 3.
REQ-039 The bench SHALL check done[owner] and the timeout in the same cycle: release occurs and timeout_err stays 0.

Source files
------------

// File: rtl/ctrl_bus_pkg.sv
// Shared types and defaults for the control-bus arbiter.
// Holds widths, the FSM state encoding and the grant timeout default.
package ctrl_bus_pkg;

  localparam int N_REQ       = 4;
  localparam int CB_W        = 17;
  localparam int TIMEOUT_DEF = 255;
  localparam int CNT_W       = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    RELEASE = 2'b10
  } state_e;

endpackage

// File: rtl/ctrl_bus_arbiter_rr_pick.sv
// Round-robin priority encoder: first set req bit at or above ptr, mod 4.
// Ports: req, ptr in; winner index and valid out (combinational).
module rr_pick
  import ctrl_bus_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       ptr,
  output logic [1:0]       winner,
  output logic             valid
);

  logic [1:0] idx;

  // Scan offsets high to low so the smallest offset from ptr wins last.
  always_comb begin
    winner = 2'd0;
    valid  = 1'b0;
    idx    = 2'd0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ctrl_bus_arbiter.sv
// Four-way round-robin control-bus arbiter with grant timeout.
// Ports: clk, reset, req, done, cbus_in, clr_err in; gnt, owner, busy,
// cbus_out, timeout_err out.
module ctrl_bus_arbiter #(
  parameter int N_REQ   = ctrl_bus_pkg::N_REQ,
  parameter int CB_W    = ctrl_bus_pkg::CB_W,
  parameter int TIMEOUT = ctrl_bus_pkg::TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        done,
  input  logic [N_REQ*CB_W-1:0]   cbus_in,
  input  logic                    clr_err,
  output logic [N_REQ-1:0]        gnt,
  output logic [1:0]              owner,
  output logic                    busy,
  output logic [CB_W-1:0]         cbus_out,
  output logic                    timeout_err
);

  import ctrl_bus_pkg::*;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [1:0]         owner_q, owner_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               err_set;
  logic               rel;
  logic [1:0]         pick_winner;
  logic               pick_valid;

  rr_pick u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  // Only the owner's done/req can end a grant.
  assign rel = done[owner_q] | ~req[owner_q];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d              = GRANT;
          gnt_d                = '0;
          gnt_d[pick_winner]   = 1'b1;
          owner_d              = pick_winner;
          ptr_d                = pick_winner + 2'd1;
          cnt_d                = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          state_d = RELEASE;
          gnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = RELEASE;
          gnt_d   = '0;
          err_set = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    // A new timeout outranks a simultaneous clear.
    if (err_set)      err_d = 1'b1;
    else if (clr_err) err_d = 1'b0;
    else              err_d = err_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign gnt         = gnt_q;
  assign owner       = owner_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = err_q;
  assign cbus_out    = (state_q == GRANT)
                     ? cbus_in[owner_q*CB_W +: CB_W]
                     : '0;

endmodule

// File: tb/tb_ctrl_bus_arbiter.sv
// Self-checking bench for ctrl_bus_arbiter: directed scenarios plus
// randomized traffic, all compared against a behavioural model.
module tb_ctrl_bus_arbiter;

  localparam int NR = 4;
  localparam int CW = 17;
  localparam int TO = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NR-1:0]    req = '0;
  logic [NR-1:0]    done = '0;
  logic [NR*CW-1:0] cbus_in = '0;
  logic             clr_err = 1'b0;
  logic [NR-1:0]    gnt;
  logic [1:0]       owner;
  logic             busy;
  logic [CW-1:0]    cbus_out;
  logic             timeout_err;

  int tests = 0;
  int fails = 0;

  // Model: phase 0 idle, 1 granted, 2 release gap.
  int m_phase = 0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_len   = 0;
  bit m_err   = 1'b0;

  ctrl_bus_arbiter #(.N_REQ(NR), .CB_W(CW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .done        (done),
    .cbus_in     (cbus_in),
    .clr_err     (clr_err),
    .gnt         (gnt),
    .owner       (owner),
    .busy        (busy),
    .cbus_out    (cbus_out),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] word_of(input int i);
    return cbus_in[i*CW +: CW];
  endfunction

  task automatic model_step();
    bit set;
    set = 1'b0;
    if (reset) begin
      m_phase = 0; m_owner = 0; m_ptr = 0; m_len = 0; m_err = 1'b0;
      return;
    end
    case (m_phase)
      0: begin
        for (int k = 0; k < NR; k++) begin
          int c;
          c = (m_ptr + k) % NR;
          if (req[c]) begin
            m_owner = c;
            m_ptr   = (c + 1) % NR;
            m_len   = 0;
            m_phase = 1;
            break;
          end
        end
      end
      1: begin
        m_len++;
        if (done[m_owner] || !req[m_owner]) m_phase = 2;
        else if (m_len == TO) begin
          m_phase = 2;
          set = 1'b1;
        end
      end
      default: m_phase = 0;
    endcase
    if (set) m_err = 1'b1;
    else if (clr_err) m_err = 1'b0;
  endtask

  task automatic check_model();
    logic [31:0] eg;
    eg = (m_phase == 1) ? 32'(1 << m_owner) : 32'd0;
    chk("gnt", 32'(gnt), eg);
    chk("owner", 32'(owner), 32'(m_owner));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("cbus_out", 32'(cbus_out),
        (m_phase == 1) ? 32'(word_of(m_owner)) : 32'd0);
    chk("timeout_err", 32'(timeout_err), 32'(m_err));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic rnd_bus();
    cbus_in = (NR*CW)'({$urandom(), $urandom(), $urandom()});
  endtask

  logic [3:0] order [5];

  initial begin
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;
    rnd_bus();

    // Reset state
    cycle();
    cycle();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cbus", 32'(cbus_out), 32'd0);
    chk("rst_err", 32'(timeout_err), 32'd0);
    reset = 1'b0;

    // First grant to requester 0
    req = 4'b0001;
    cycle();
    chk("g0_gnt", 32'(gnt), 32'h1);
    chk("g0_busy", 32'(busy), 32'd1);
    chk("g0_cbus", 32'(cbus_out), 32'(cbus_in[16:0]));
    req = 4'b0000;
    cycle();
    chk("g0_rel", 32'(gnt), 32'd0);
    cycle();

    // Round-robin order with all requesting
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      rnd_bus();
      cycle();
      chk("rr_gnt", 32'(gnt), 32'(order[i]));
      done = order[i];
      cycle();
      done = 4'b0000;
      chk("rr_gap1", 32'(gnt), 32'd0);
      cycle();
      chk("rr_gap2", 32'(gnt), 32'd0);
    end

    // Non-owner done is ignored
    cycle();
    chk("no_gnt", 32'(gnt), 32'b0010);
    done = 4'b0100;
    cycle();
    chk("no_hold1", 32'(gnt), 32'b0010);
    cycle();
    chk("no_hold2", 32'(gnt), 32'b0010);
    done = 4'b0010;
    cycle();
    done = 4'b0000;
    req = 4'b0000;
    chk("no_rel", 32'(gnt), 32'd0);
    cycle();

    // Timeout after TO grant cycles; error sticky until cleared
    req = 4'b0100;
    for (int i = 0; i < TO; i++) begin
      cycle();
      chk("to_gnt", 32'(gnt), 32'b0100);
    end
    cycle();
    chk("to_drop", 32'(gnt), 32'd0);
    chk("to_err", 32'(timeout_err), 32'd1);
    req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("to_sticky", 32'(timeout_err), 32'd1);
    end
    clr_err = 1'b1;
    cycle();
    clr_err = 1'b0;
    chk("to_clr", 32'(timeout_err), 32'd0);

    // done coincident with timeout: normal release
    req = 4'b0001;
    for (int i = 0; i < TO; i++) begin
      cycle();
      chk("co_gnt", 32'(gnt), 32'b0001);
    end
    done = 4'b0001;
    cycle();
    done = 4'b0000;
    req = 4'b0000;
    chk("co_drop", 32'(gnt), 32'd0);
    chk("co_err", 32'(timeout_err), 32'd0);
    cycle();
    cycle();

    // Reset mid-grant
    req = 4'b1111;
    cycle();
    cycle();
    chk("mr_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("mr_gnt", 32'(gnt), 32'd0);
    chk("mr_cbus", 32'(cbus_out), 32'd0);
    chk("mr_ptr", 32'(dut.ptr_q), 32'd0);
    chk("mr_busy0", 32'(busy), 32'd0);
    req = 4'b1000;
    cycle();
    chk("mr_gnt3", 32'(gnt), 32'b1000);
    chk("mr_own3", 32'(owner), 32'd3);
    req = 4'b0000;
    cycle();
    cycle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom());
      done    = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'b0000;
      clr_err = ($urandom_range(0, 15) == 0);
      reset   = ($urandom_range(0, 199) == 0);
      rnd_bus();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
